// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PCTL_RUN,
      PCTL_MUL_WAIT,
      PCTL_MEM_WAIT
   } pctl_state_t;

   // Stage index constants; the D..W entries name the register feeding that stage.
   localparam int STG_F = 0;
   localparam int STG_D = 1;
   localparam int STG_E = 2;
   localparam int STG_M = 3;
   localparam int STG_W = 4;

   typedef struct packed {
      logic en;
      logic clr;
   } pctl_stage_ctrl_t;

   localparam pctl_stage_ctrl_t STG_PASS   = '{en: 1'b1, clr: 1'b0};
   localparam pctl_stage_ctrl_t STG_HOLD   = '{en: 1'b0, clr: 1'b0};
   localparam pctl_stage_ctrl_t STG_BUBBLE = '{en: 1'b1, clr: 1'b1};

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pctl_cnt.sv
// Loadable up/down wait counter with zero and limit flags, shared by the
// multi-cycle and memory wait states.
module pctl_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic [W-1:0] limit_i,
   output logic         zero_o,
   output logic         at_limit_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (inc_i)
         cnt_d = cnt_q + 1'b1;
      else if (dec_i)
         cnt_d = cnt_q - 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o     = (cnt_q == '0);
   assign at_limit_o = (cnt_q >= limit_i);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the F-D-E-M-W pipeline (same-cycle stall decode).
// Perf counters are built only when PIPE_STALL_CTRL_PERF_EN is defined.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT     = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lu_hazard,
   input  logic             br_taken_e,
   input  logic             mul_start_e,
   input  logic             mem_req_m,
   input  logic             mem_ready,
   output logic             en_f,
   output logic             en_fd,
   output logic             en_de,
   output logic             en_em,
   output logic             en_mw,
   output logic             clr_fd,
   output logic             clr_de,
   output logic             clr_em,
   output logic             clr_mw,
   output logic             mem_timeout,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int CW = $clog2(max_int(MUL_LAT, MEM_TIMEOUT) + 1);

   pctl_state_t      state_q;
   pctl_state_t      state_d;
   logic             timeout_q;
   logic             timeout_set;
   logic             release_c;
   logic             pc_en;
   pctl_stage_ctrl_t stg [STG_D:STG_W];

   logic             cnt_ld;
   logic [CW-1:0]    cnt_ld_val;
   logic             cnt_inc;
   logic             cnt_dec;
   logic             cnt_zero;
   logic             cnt_at_lim;

   pctl_cnt #(.W(CW)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cnt_ld),
      .load_val_i (cnt_ld_val),
      .inc_i      (cnt_inc),
      .dec_i      (cnt_dec),
      .limit_i    (CW'(MEM_TIMEOUT)),
      .zero_o     (cnt_zero),
      .at_limit_o (cnt_at_lim)
   );

   always_comb begin
      state_d     = state_q;
      cnt_ld      = 1'b0;
      cnt_ld_val  = '0;
      cnt_inc     = 1'b0;
      cnt_dec     = 1'b0;
      timeout_set = 1'b0;
      release_c   = 1'b0;
      pc_en       = 1'b1;
      for (int s = STG_D; s <= STG_W; s++)
         stg[s] = STG_PASS;

      case (state_q)
         PCTL_RUN: begin
            if (mem_req_m && !mem_ready) begin
               pc_en      = 1'b0;
               stg[STG_D] = STG_HOLD;
               stg[STG_E] = STG_HOLD;
               stg[STG_M] = STG_HOLD;
               stg[STG_W] = STG_BUBBLE;
               cnt_ld     = 1'b1;
               cnt_ld_val = CW'(1);
               state_d    = PCTL_MEM_WAIT;
            end else if (mul_start_e) begin
               pc_en      = 1'b0;
               stg[STG_D] = STG_HOLD;
               stg[STG_E] = STG_HOLD;
               stg[STG_M] = STG_BUBBLE;
               cnt_ld     = 1'b1;
               cnt_ld_val = CW'(MUL_LAT - 1);
               state_d    = PCTL_MUL_WAIT;
            end else begin
               release_c = 1'b1;
            end
         end
         PCTL_MUL_WAIT: begin
            if (!cnt_zero) begin
               pc_en      = 1'b0;
               stg[STG_D] = STG_HOLD;
               stg[STG_E] = STG_HOLD;
               stg[STG_M] = STG_BUBBLE;
               cnt_dec    = 1'b1;
            end else begin
               release_c = 1'b1;
               state_d   = PCTL_RUN;
            end
         end
         PCTL_MEM_WAIT: begin
            if (mem_ready || cnt_at_lim) begin
               release_c   = 1'b1;
               timeout_set = !mem_ready;
               state_d     = PCTL_RUN;
            end else begin
               pc_en      = 1'b0;
               stg[STG_D] = STG_HOLD;
               stg[STG_E] = STG_HOLD;
               stg[STG_M] = STG_HOLD;
               stg[STG_W] = STG_BUBBLE;
               cnt_inc    = 1'b1;
            end
         end
         default: state_d = PCTL_RUN;
      endcase

      // Release cycles (plain RUN or wait exit) only honour flush and load-use.
      if (release_c) begin
         if (br_taken_e) begin
            stg[STG_D] = STG_BUBBLE;
            stg[STG_E] = STG_BUBBLE;
         end else if (lu_hazard) begin
            pc_en      = 1'b0;
            stg[STG_D] = STG_HOLD;
            stg[STG_E] = STG_BUBBLE;
         end
      end

      if (reset) begin
         pc_en = 1'b0;
         for (int s = STG_D; s <= STG_W; s++)
            stg[s] = '0;
      end
   end

   // NOTE: asynchronous reset appears in the sensitivity list; it is active-high here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= PCTL_RUN;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (timeout_set)
            timeout_q <= 1'b1;
      end
   end

   assign en_f        = pc_en;
   assign en_fd       = stg[STG_D].en;
   assign en_de       = stg[STG_E].en;
   assign en_em       = stg[STG_M].en;
   assign en_mw       = stg[STG_W].en;
   assign clr_fd      = stg[STG_D].clr;
   assign clr_de      = stg[STG_E].clr;
   assign clr_em      = stg[STG_M].clr;
   assign clr_mw      = stg[STG_W].clr;
   assign mem_timeout = timeout_q;
   assign busy        = !reset && (state_q != PCTL_RUN);

`ifdef PIPE_STALL_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Saturating event counters; reset cycles are excluded by the reset branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!en_f && !(&stall_q))
            stall_q <= stall_q + 1'b1;
         if (clr_fd && !(&flush_q))
            flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

`ifndef SYNTHESIS
   a_no_mul_with_branch: assert property (@(posedge clk) disable iff (reset)
      !(mul_start_e && br_taken_e));
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// stimulus against a stall-cycle-counting reference model.
module tb_pipe_stall_ctrl;

   localparam int MUL_LAT     = 4;
   localparam int MEM_TIMEOUT = 8;
   localparam int CNT_W       = 32;

   // Output vector order: {en_f,en_fd,en_de,en_em,en_mw,clr_fd,clr_de,clr_em,clr_mw}
   localparam logic [8:0] V_RUN = 9'b11111_0000;
   localparam logic [8:0] V_LU  = 9'b00111_0100;
   localparam logic [8:0] V_BR  = 9'b11111_1100;
   localparam logic [8:0] V_MUL = 9'b00011_0010;
   localparam logic [8:0] V_MEM = 9'b00001_0001;

   logic clk = 1'b0;
   logic reset, lu_hazard, br_taken_e, mul_start_e, mem_req_m, mem_ready;
   logic en_f, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw;
   logic mem_timeout, busy;
   logic [CNT_W-1:0] stall_cycles, flush_events;
   logic [8:0] dut_o;

   int n_cmp = 0;
   int n_err = 0;

   pipe_stall_ctrl #(.MUL_LAT(MUL_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .lu_hazard(lu_hazard), .br_taken_e(br_taken_e),
      .mul_start_e(mul_start_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
      .en_f(en_f), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
      .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
      .mem_timeout(mem_timeout), .busy(busy),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   assign dut_o = {en_f, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw};

   // Reference model: which wait is pending and how many stall cycles it has used.
   int          m_kind;     // 0 none, 1 multi-cycle op, 2 memory
   int          m_elapsed;
   bit          m_to;
   int unsigned m_stall, m_flush;
   int          n_kind, n_elapsed;
   bit          n_to;
   logic [8:0]  exp_o;
   bit          exp_busy, exp_to;
   logic [CNT_W-1:0] exp_stall, exp_flush;

   function automatic logic [8:0] release_vec();
      if (br_taken_e) return V_BR;
      if (lu_hazard)  return V_LU;
      return V_RUN;
   endfunction

   task automatic model_eval();
      n_kind    = m_kind;
      n_elapsed = m_elapsed;
      n_to      = m_to;
      exp_busy  = (m_kind != 0);
      if (reset) begin
         exp_o = '0; exp_busy = 1'b0; n_kind = 0; n_elapsed = 0; n_to = 1'b0;
      end else if (m_kind == 0) begin
         if (mem_req_m && !mem_ready) begin
            exp_o = V_MEM; n_kind = 2; n_elapsed = 1;
         end else if (mul_start_e) begin
            exp_o = V_MUL; n_kind = 1; n_elapsed = 1;
         end else
            exp_o = release_vec();
      end else if (m_kind == 1) begin
         if (m_elapsed < MUL_LAT) begin
            exp_o = V_MUL; n_elapsed = m_elapsed + 1;
         end else begin
            exp_o = release_vec(); n_kind = 0;
         end
      end else begin
         if (mem_ready) begin
            exp_o = release_vec(); n_kind = 0;
         end else if (m_elapsed >= MEM_TIMEOUT) begin
            exp_o = release_vec(); n_kind = 0; n_to = 1'b1;
         end else begin
            exp_o = V_MEM; n_elapsed = m_elapsed + 1;
         end
      end
      exp_to = reset ? 1'b0 : m_to;
`ifdef PIPE_STALL_CTRL_PERF_EN
      exp_stall = reset ? '0 : CNT_W'(m_stall);
      exp_flush = reset ? '0 : CNT_W'(m_flush);
`else
      exp_stall = '0;
      exp_flush = '0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      m_kind    = n_kind;
      m_elapsed = n_elapsed;
      m_to      = n_to;
      if (reset) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (!exp_o[8]) m_stall++;
         if (exp_o[3])  m_flush++;
      end
      #1;
   endtask

   task automatic drive(input bit lu, input bit br, input bit mul, input bit req, input bit rdy);
      lu_hazard = lu; br_taken_e = br; mul_start_e = mul; mem_req_m = req; mem_ready = rdy;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== 9'b0) begin n_err++; $display("FAIL reset_outs got %b want %b", dut_o, 9'b0); end
      n_cmp++; if (busy !== 1'b0 || mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_flags got busy=%b to=%b want 0 0", busy, mem_timeout); end
      n_cmp++; if (stall_cycles !== '0 || flush_events !== '0) begin n_err++; $display("FAIL reset_perf got %0d %0d want 0 0", stall_cycles, flush_events); end
      tick();
      reset = 1'b0;
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== V_RUN) begin n_err++; $display("FAIL idle_outs got %b want %b", dut_o, V_RUN); end
      tick();
   endtask

   task automatic test_load_use();
      drive(1, 0, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== V_LU) begin n_err++; $display("FAIL lu_outs got %b want %b", dut_o, V_LU); end
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== V_RUN) begin n_err++; $display("FAIL lu_after got %b want %b", dut_o, V_RUN); end
      tick();
   endtask

   task automatic test_branch();
      drive(1, 1, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== V_BR) begin n_err++; $display("FAIL br_lu_outs got %b want %b", dut_o, V_BR); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL br_busy got %b want 0", busy); end
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== V_RUN) begin n_err++; $display("FAIL br_after got %b want %b", dut_o, V_RUN); end
      tick();
   endtask

   task automatic test_mul();
      int de_stalls = 0;
      drive(0, 0, 1, 0, 0);
      for (int c = 1; c <= MUL_LAT + 1; c++) begin
         @(negedge clk); model_eval();
         n_cmp++; if (dut_o !== exp_o) begin n_err++; $display("FAIL mul_c%0d got %b want %b", c, dut_o, exp_o); end
         if (c > 1 && c <= MUL_LAT) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_c%0d got %b want 1", c, busy); end
         end
         if (en_de === 1'b0) de_stalls++;
         tick();
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (de_stalls != MUL_LAT) begin n_err++; $display("FAIL mul_stall_len got %0d want %0d", de_stalls, MUL_LAT); end
      n_cmp++; if (busy !== 1'b0 || dut_o !== V_RUN) begin n_err++; $display("FAIL mul_after got busy=%b %b want 0 %b", busy, dut_o, V_RUN); end
      tick();
   endtask

   task automatic test_mem(input bit br_on_release, input string tag);
      logic [8:0] want;
      for (int c = 1; c <= 4; c++) begin
         if (c < 4) drive(0, 0, 0, 1, 0);
         else       drive(0, br_on_release, 0, 1, 1);
         @(negedge clk); model_eval();
         want = (c < 4) ? V_MEM : (br_on_release ? V_BR : V_RUN);
         n_cmp++; if (dut_o !== want || exp_o !== want) begin n_err++; $display("FAIL %s_c%0d got %b want %b", tag, c, dut_o, want); end
         tick();
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (busy !== 1'b0 || mem_timeout !== 1'b0) begin n_err++; $display("FAIL %s_after got busy=%b to=%b want 0 0", tag, busy, mem_timeout); end
      tick();
   endtask

   task automatic test_timeout();
      int stalls = 0;
      drive(0, 0, 0, 1, 0);
      for (int c = 1; c <= MEM_TIMEOUT + 1; c++) begin
         @(negedge clk); model_eval();
         n_cmp++; if (dut_o !== exp_o || mem_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_c%0d got %b to=%b want %b to=0", c, dut_o, mem_timeout, exp_o); end
         if (en_f === 1'b0) stalls++;
         tick();
      end
      drive(0, 0, 0, 0, 0);
      n_cmp++; if (stalls != MEM_TIMEOUT) begin n_err++; $display("FAIL tmo_stall_len got %0d want %0d", stalls, MEM_TIMEOUT); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); model_eval();
         n_cmp++; if (mem_timeout !== 1'b1 || dut_o !== V_RUN) begin n_err++; $display("FAIL tmo_sticky_%0d got to=%b %b want 1 %b", c, mem_timeout, dut_o, V_RUN); end
         tick();
      end
   endtask

   task automatic test_reset_mid_mul();
      drive(0, 0, 1, 0, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); model_eval();
         tick();
      end
      reset = 1'b1;
      #1;
      n_cmp++; if (dut_o !== 9'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_async got %b busy=%b want 0 0", dut_o, busy); end
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== exp_o || mem_timeout !== 1'b0) begin n_err++; $display("FAIL rst_mid got %b to=%b want %b to=0", dut_o, mem_timeout, exp_o); end
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval();
      n_cmp++; if (dut_o !== V_RUN || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_after got %b busy=%b want %b 0", dut_o, busy, V_RUN); end
      tick();
   endtask

   task automatic test_perf();
      logic [CNT_W-1:0] want_s, want_f;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval(); tick();
      reset = 1'b0;
      drive(1, 0, 0, 0, 0);
      @(negedge clk); model_eval(); tick();
      drive(0, 0, 1, 0, 0);
      for (int c = 0; c <= MUL_LAT; c++) begin
         @(negedge clk); model_eval(); tick();
      end
      drive(0, 1, 0, 0, 0);
      @(negedge clk); model_eval(); tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk); model_eval();
`ifdef PIPE_STALL_CTRL_PERF_EN
      want_s = CNT_W'(1 + MUL_LAT);
      want_f = CNT_W'(1);
`else
      want_s = '0;
      want_f = '0;
`endif
      n_cmp++; if (stall_cycles !== want_s) begin n_err++; $display("FAIL perf_stall got %0d want %0d", stall_cycles, want_s); end
      n_cmp++; if (flush_events !== want_f) begin n_err++; $display("FAIL perf_flush got %0d want %0d", flush_events, want_f); end
      tick();
   endtask

   task automatic test_random();
      bit mul;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(63) == 0);
         mul   = ($urandom_range(5) == 0);
         drive($urandom_range(3) == 0, !mul && ($urandom_range(4) == 0), mul,
               $urandom_range(3) == 0, $urandom_range(2) == 0);
         @(negedge clk); model_eval();
         n_cmp++; if (dut_o !== exp_o) begin n_err++; $display("FAIL rnd%0d outs got %b want %b", i, dut_o, exp_o); end
         n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL rnd%0d busy got %b want %b", i, busy, exp_busy); end
         n_cmp++; if (mem_timeout !== exp_to) begin n_err++; $display("FAIL rnd%0d timeout got %b want %b", i, mem_timeout, exp_to); end
         n_cmp++; if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin
            n_err++; $display("FAIL rnd%0d perf got %0d/%0d want %0d/%0d", i, stall_cycles, flush_events, exp_stall, exp_flush);
         end
         tick();
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      m_kind = 0; m_elapsed = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
      test_reset();
      test_load_use();
      test_branch();
      test_mul();
      test_mem(1'b0, "mem");
      test_mem(1'b1, "mem_br");
      test_timeout();
      test_reset_mid_mul();
      test_perf();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
